// File: rtl/game_pkg.sv
// Shared types and default parameters for the game-control blocks.
// The guard FSM state encoding lives here so the datapath and bench can share it.
package game_pkg;

  typedef enum logic [1:0] {
    G_NORMAL,
    G_GUARD,
    G_EXHAUSTED
  } guard_state_t;

  localparam int STAMINA_MAX_D     = 15;
  localparam int STAMINA_RECOVER_D = 8;
  localparam int REGEN_DIV_D       = 4;

endpackage

// File: rtl/player_cmd_ctrl_if.sv
// Button-side inputs and datapath-side command outputs of one player controller.
// The master drives buttons/tick/isJ; the controller (slave) drives the commands.
interface player_cmd_ctrl_if #(
  parameter int SW = 4
);
  logic          frame_tick;
  logic          btn_right;
  logic          btn_left;
  logic          btn_jump;
  logic          btn_squat;
  logic          btn_defend;
  logic          isJ;
  logic          right;
  logic          left;
  logic          jump;
  logic          squat;
  logic          defend;
  logic [SW-1:0] stamina;
  logic          exhausted;

  modport master (
    output frame_tick, btn_right, btn_left, btn_jump, btn_squat, btn_defend, isJ,
    input  right, left, jump, squat, defend, stamina, exhausted
  );

  modport slave (
    input  frame_tick, btn_right, btn_left, btn_jump, btn_squat, btn_defend, isJ,
    output right, left, jump, squat, defend, stamina, exhausted
  );
endinterface

// File: rtl/player_cmd_ctrl_stamina_meter.sv
// Saturating stamina register with a frame-divided regeneration counter.
// stamina_nxt is the value the register takes on the coming tick.
module stamina_meter #(
  parameter int STAMINA_MAX = 15,
  parameter int REGEN_DIV   = 4,
  parameter int SW          = $clog2(STAMINA_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          drain,
  input  logic          regen_en,
  output logic [SW-1:0] stamina,
  output logic [SW-1:0] stamina_nxt,
  output logic          empty
);

  localparam int CW = (REGEN_DIV > 1) ? $clog2(REGEN_DIV) : 1;

  logic [SW-1:0] stamina_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Drain takes precedence and restarts the regen phase so a fresh
  // recovery always needs REGEN_DIV frames for its first point.
  always_comb begin
    cnt_nxt     = cnt;
    stamina_nxt = stamina_q;
    if (drain) begin
      cnt_nxt = '0;
      if (stamina_q != '0) stamina_nxt = stamina_q - SW'(1);
    end else if (regen_en) begin
      if (cnt == CW'(REGEN_DIV - 1)) begin
        cnt_nxt = '0;
        if (stamina_q != SW'(STAMINA_MAX)) stamina_nxt = stamina_q + SW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamina_q <= SW'(STAMINA_MAX);
      cnt       <= '0;
    end else if (tick) begin
      stamina_q <= stamina_nxt;
      cnt       <= cnt_nxt;
    end
  end

  assign stamina = stamina_q;
  assign empty   = (stamina_q == '0);

endmodule

// File: rtl/player_cmd_ctrl.sv
// Per-player command controller: frame-sampled buttons, fixed priority, defend stamina guard.
//   state       | meaning
//   G_NORMAL    | free play, defend allowed when stamina > 0, stamina regenerates
//   G_GUARD     | defending, all other actions blocked, stamina drains 1 per frame
//   G_EXHAUSTED | defend locked out until stamina regenerates to STAMINA_RECOVER
module player_cmd_ctrl
  import game_pkg::*;
#(
  parameter int STAMINA_MAX     = STAMINA_MAX_D,
  parameter int STAMINA_RECOVER = STAMINA_RECOVER_D,
  parameter int REGEN_DIV       = REGEN_DIV_D,
  parameter int SW              = $clog2(STAMINA_MAX + 1)
) (
  input logic               clk,
  input logic               rst,
  player_cmd_ctrl_if.slave  pif
);

  guard_state_t  state;
  guard_state_t  state_nxt;
  logic          prev_jump;
  logic          guard_frame;
  logic          blocked;
  logic          squat_c;
  logic          jump_c;
  logic          right_c;
  logic          left_c;
  logic [SW-1:0] stamina;
  logic [SW-1:0] stamina_nxt;
  logic          empty;

  // A frame is a guard frame when defend is held, stamina remains and
  // the lockout is not active; this covers both entering and staying.
  assign guard_frame = pif.btn_defend && !empty && (state != G_EXHAUSTED);

  stamina_meter #(
    .STAMINA_MAX (STAMINA_MAX),
    .REGEN_DIV   (REGEN_DIV),
    .SW          (SW)
  ) u_meter (
    .clk         (clk),
    .rst         (rst),
    .tick        (pif.frame_tick),
    .drain       (guard_frame),
    .regen_en    (!guard_frame),
    .stamina     (stamina),
    .stamina_nxt (stamina_nxt),
    .empty       (empty)
  );

  always_comb begin
    state_nxt = state;
    if (guard_frame) begin
      state_nxt = (stamina_nxt == '0) ? G_EXHAUSTED : G_GUARD;
    end else if (state == G_EXHAUSTED) begin
      state_nxt = (stamina_nxt >= SW'(STAMINA_RECOVER)) ? G_NORMAL : G_EXHAUSTED;
    end else begin
      state_nxt = G_NORMAL;
    end
  end

  // Priority is resolved against the state this frame ends in.
  always_comb begin
    blocked = (state_nxt == G_GUARD);
    squat_c = !blocked && pif.btn_squat && !pif.isJ;
    jump_c  = !blocked && !squat_c && pif.btn_jump && !prev_jump && !pif.isJ;
    right_c = !blocked && !squat_c && pif.btn_right && !pif.btn_left;
    left_c  = !blocked && !squat_c && pif.btn_left && !pif.btn_right;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= G_NORMAL;
      prev_jump     <= 1'b0;
      pif.right     <= 1'b0;
      pif.left      <= 1'b0;
      pif.jump      <= 1'b0;
      pif.squat     <= 1'b0;
      pif.defend    <= 1'b0;
      pif.exhausted <= 1'b0;
    end else if (pif.frame_tick) begin
      state         <= state_nxt;
      prev_jump     <= pif.btn_jump;
      pif.right     <= right_c;
      pif.left      <= left_c;
      pif.jump      <= jump_c;
      pif.squat     <= squat_c;
      pif.defend    <= (state_nxt == G_GUARD);
      pif.exhausted <= (state_nxt == G_EXHAUSTED);
    end else begin
      pif.right     <= 1'b0;
      pif.left      <= 1'b0;
      pif.jump      <= 1'b0;
    end
  end

  assign pif.stamina = stamina;

endmodule

// File: tb/tb_player_cmd_ctrl.sv
// Directed-vector bench for player_cmd_ctrl with default parameters (15/8/4).
// Observation word: {right,left,jump,squat,defend,exhausted,stamina[3:0]}.
module tb_player_cmd_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  player_cmd_ctrl_if #(.SW(4)) pif ();

  player_cmd_ctrl #(
    .STAMINA_MAX     (15),
    .STAMINA_RECOVER (8),
    .REGEN_DIV       (4),
    .SW              (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {btn_right, btn_left, btn_jump, btn_squat, btn_defend, isJ}
  typedef struct {
    string      name;
    logic [5:0] in;
    logic [9:0] exp;
  } vec_t;

  localparam logic [9:0] LEVEL_MASK = 10'b00_0111_1111;

  function automatic logic [9:0] obs();
    return {pif.right, pif.left, pif.jump, pif.squat, pif.defend, pif.exhausted, pif.stamina};
  endfunction

  function automatic logic [9:0] mk(input logic r, input logic l, input logic j, input logic s,
                                    input logic d, input logic e, input int st);
    logic [3:0] st4;
    st4 = st[3:0];
    return {r, l, j, s, d, e, st4};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // One frame: tick with the given buttons, check the post-tick word,
  // then check the following non-tick cycle drops pulses and holds levels.
  task automatic frame(input string name, input logic [5:0] in, input logic [9:0] exp);
    @(negedge clk);
    {pif.btn_right, pif.btn_left, pif.btn_jump, pif.btn_squat, pif.btn_defend, pif.isJ} = in;
    pif.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    pif.frame_tick = 1'b0;
    check(name, obs(), exp);
    @(posedge clk);
    #1;
    check({name, "_hold"}, obs(), exp & LEVEL_MASK);
  endtask

  vec_t vecs[$];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    pif.frame_tick = 1'b0;
    pif.btn_right  = 1'b0;
    pif.btn_left   = 1'b0;
    pif.btn_jump   = 1'b0;
    pif.btn_squat  = 1'b0;
    pif.btn_defend = 1'b0;
    pif.isJ        = 1'b0;

    vecs.push_back('{"right",        6'b100000, mk(1,0,0,0,0,0,15)});
    vecs.push_back('{"both_dirs",    6'b110000, mk(0,0,0,0,0,0,15)});
    vecs.push_back('{"left",         6'b010000, mk(0,1,0,0,0,0,15)});
    vecs.push_back('{"jump_press",   6'b001000, mk(0,0,1,0,0,0,15)});
    vecs.push_back('{"jump_held2",   6'b001000, mk(0,0,0,0,0,0,15)});
    vecs.push_back('{"jump_held3",   6'b001000, mk(0,0,0,0,0,0,15)});
    vecs.push_back('{"idle",         6'b000000, mk(0,0,0,0,0,0,15)});
    vecs.push_back('{"jump_air",     6'b001001, mk(0,0,0,0,0,0,15)});
    vecs.push_back('{"squat_air",    6'b010101, mk(0,1,0,0,0,0,15)});
    vecs.push_back('{"squat_blocks", 6'b100100, mk(0,0,0,1,0,0,15)});
    vecs.push_back('{"guard_block",  6'b101110, mk(0,0,0,0,1,0,14)});
    vecs.push_back('{"guard_rel",    6'b001000, mk(0,0,0,0,0,0,14)});
    vecs.push_back('{"squat_after",  6'b000100, mk(0,0,0,1,0,0,14)});
    vecs.push_back('{"regen_a",      6'b000000, mk(0,0,0,0,0,0,14)});
    vecs.push_back('{"regen_b",      6'b000000, mk(0,0,0,0,0,0,15)});

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), mk(0,0,0,0,0,0,15));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) frame(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Defend until empty: the 15th frame drops defend and locks out.
    for (int i = 1; i <= 15; i++)
      frame($sformatf("drain_%0d", i), 6'b000010, mk(0,0,0,0,(i < 15),(i == 15),15 - i));

    // Recovery: +1 per 4 frames; defend ignored, moves still allowed.
    for (int k = 1; k <= 32; k++)
      frame($sformatf("recover_%0d", k), {(k == 5), 3'b000, (k <= 4), 1'b0},
            mk((k == 5),0,0,0,0,(k < 32),k / 4));

    frame("reguard_a", 6'b000010, mk(0,0,0,0,1,0,7));
    frame("reguard_b", 6'b000010, mk(0,0,0,0,1,0,6));
    frame("reguard_c", 6'b000010, mk(0,0,0,0,1,0,5));

    // Asynchronous reset mid-cycle while guarding with stamina 5.
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", obs(), mk(0,0,0,0,0,0,15));
    @(negedge clk);
    rst = 1'b0;
    frame("post_reset_guard", 6'b000010, mk(0,0,0,0,1,0,14));
    frame("post_reset_rel",   6'b000000, mk(0,0,0,0,0,0,14));

    // Back-to-back ticks: each one is a full frame producing its own pulse.
    @(negedge clk);
    {pif.btn_right, pif.btn_left, pif.btn_jump, pif.btn_squat, pif.btn_defend, pif.isJ} = 6'b100000;
    pif.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first", obs(), mk(1,0,0,0,0,0,14));
    @(posedge clk);
    #1;
    pif.frame_tick = 1'b0;
    check("b2b_second", obs(), mk(1,0,0,0,0,0,14));
    @(posedge clk);
    #1;
    check("b2b_after", obs(), mk(0,0,0,0,0,0,14));
    frame("b2b_regen", 6'b000000, mk(0,0,0,0,0,0,15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
